// File: rtl/ternary_pkg.sv
// Shared trit encodings, FSM state type and half-add helper for the ternary serial adder.
package ternary_pkg;

   localparam logic [1:0] TRIT_0   = 2'b00;
   localparam logic [1:0] TRIT_1   = 2'b01;
   localparam logic [1:0] TRIT_2   = 2'b10;
   localparam logic [1:0] TRIT_BAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADD  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Half add of two legal trits: returns {carry, sum_trit}.
   function automatic logic [2:0] trit_half_add(input logic [1:0] x, input logic [1:0] y);
      logic [2:0] t;
      logic       c;
      t = {1'b0, x} + {1'b0, y};
      c = 1'b0;
      if (t >= 3'd3) begin
         t = t - 3'd3;
         c = 1'b1;
      end
      return {c, t[1:0]};
   endfunction

endpackage

// File: rtl/ternary_digit_adder.sv
// Combinational ternary full-adder digit built from two half-add stages.
module ternary_digit_adder
   import ternary_pkg::*;
(
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   input  logic       carry_i,
   output logic [1:0] sum_o,
   output logic       carry_o
);

   logic [2:0] stage1;
   logic [2:0] stage2;

   // a+b first, then fold in the carry; the two partial carries can never both be set.
   always_comb begin
      stage1  = trit_half_add(a_i, b_i);
      stage2  = trit_half_add(stage1[1:0], {1'b0, carry_i});
      sum_o   = stage2[1:0];
      carry_o = stage1[2] | stage2[2];
   end

endmodule

// File: rtl/ternary_serial_adder.sv
// Digit-serial ternary adder: one trit per clock, LSD first, valid/ready on both sides.
// Optional feature macro: TERNARY_ILLEGAL_CHECK_EN (sticky err on any 11-coded operand trit).
// Without the macro err is tied 0; 11 trits are masked to 0 for arithmetic in both builds.
module ternary_serial_adder
   import ternary_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  CLOCK_50,
   input  logic                  RESETN,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*DIGITS-1:0]   a,
   input  logic [2*DIGITS-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*DIGITS-1:0]   sum,
   output logic                  carry_out,
   output logic                  err
);

   localparam int unsigned CNT_W = $clog2(DIGITS + 1);
   localparam int unsigned W     = 2 * DIGITS;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]      dig_a, dig_b, dig_sum;
   logic            dig_carry;
   logic [W-1:0]    sum_ins;

   // Current digit always sits at the bottom of the operand shift registers.
   always_comb begin
      dig_a = (a_q[1:0] == TRIT_BAD) ? TRIT_0 : a_q[1:0];
      dig_b = (b_q[1:0] == TRIT_BAD) ? TRIT_0 : b_q[1:0];
   end

   ternary_digit_adder u_digit (
      .a_i     (dig_a),
      .b_i     (dig_b),
      .carry_i (carry_q),
      .sum_o   (dig_sum),
      .carry_o (dig_carry)
   );

   // New sum trit enters at the MSD end so the result is LSD-aligned after DIGITS shifts.
   always_comb begin
      sum_ins          = '0;
      sum_ins[W-1-:2]  = dig_sum;
   end

`ifdef TERNARY_ILLEGAL_CHECK_EN
   logic err_q, err_d;
   logic bad_trit;

   // Flag any illegal trit of the digit being consumed this cycle.
   always_comb begin
      bad_trit = (a_q[1:0] == TRIT_BAD) || (b_q[1:0] == TRIT_BAD);
   end

   // Sticky error: cleared on accept, set by any illegal trit while adding.
   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && in_valid) begin
         err_d = 1'b0;
      end else if (state_q == ADD && bad_trit) begin
         err_d = 1'b1;
      end
   end

   // Error flag register.
   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Next-state and datapath update for the accept/add/hold sequence.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            a_d     = a_q >> 2;
            b_d     = b_q >> 2;
            sum_d   = (sum_q >> 2) | sum_ins;
            carry_d = dig_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand, sum, carry and counter registers.
   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_ternary_serial_adder.sv
// Directed self-checking bench for ternary_serial_adder (DIGITS=4).
module tb_ternary_serial_adder;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 2 * DIGITS;

`ifdef TERNARY_ILLEGAL_CHECK_EN
   localparam logic EXP_BAD_ERR = 1'b1;
`else
   localparam logic EXP_BAD_ERR = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;

   ternary_serial_adder #(
      .DIGITS (DIGITS)
   ) dut (
      .CLOCK_50  (clk),
      .RESETN    (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present operands at a negedge once in_ready is up; returns at the negedge after accept.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_val("in_ready_timeout", 32'(in_ready), 32'd1);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count accept-to-out_valid edges, bounded.
   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] es, input logic ec, input logic ee);
      int n;
      start_op(av, bv);
      wait_out(n);
      check_val({tag, "_lat"}, 32'(n), 32'd4);
      check_val({tag, "_sum"}, 32'(sum), 32'(es));
      check_val({tag, "_cout"}, 32'(carry_out), 32'(ec));
      check_val({tag, "_err"}, 32'(err), 32'(ee));
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [W-1:0] pa [3];
   logic [W-1:0] pb [3];
   logic [W-1:0] ps [3];
   logic         pc [3];

   initial begin
      int n;
      int idx;
      int res;
      int t_res [3];
      bit acc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      #12;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_sum", 32'(sum), 32'd0);
      check_val("rst_cout", 32'(carry_out), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 34 + 14 = 48
      run_add("basic", 8'h49, 8'h16, 8'h64, 1'b0, 1'b0);
      // 80 + 1 = 81 -> overflow
      run_add("ovf1", 8'hAA, 8'h01, 8'h00, 1'b1, 1'b0);
      // 80 + 80 = 160
      run_add("ovf2", 8'hAA, 8'hAA, 8'hA9, 1'b1, 1'b0);
      // Illegal LSD in a, treated as 0
      run_add("bad", 8'h03, 8'h01, 8'h01, 1'b0, EXP_BAD_ERR);
      run_add("clean", 8'h05, 8'h05, 8'h0A, 1'b0, 1'b0);

      // Backpressure: 11 + 19 = 30 = 1010_3
      out_ready = 1'b0;
      start_op(8'h12, 8'h21);
      wait_out(n);
      check_val("bp_lat", 32'(n), 32'd4);
      a        = 8'h01;
      b        = 8'h01;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_val("bp_hold_valid", 32'(out_valid), 32'd1);
         check_val("bp_hold_sum", 32'(sum), 32'h44);
         check_val("bp_hold_cout", 32'(carry_out), 32'd0);
         check_val("bp_hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("bp_idle_ready", 32'(in_ready), 32'd1);
      check_val("bp_idle_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_val("bp_accepted", 32'(in_ready), 32'd0);
      wait_out(n);
      check_val("bp2_lat", 32'(n), 32'd4);
      check_val("bp2_sum", 32'(sum), 32'h02);
      @(posedge clk);
      @(negedge clk);

      // Reset during second ADD cycle
      start_op(8'h49, 8'h16);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_sum", 32'(sum), 32'd0);
      check_val("mid_rst_cout", 32'(carry_out), 32'd0);
      check_val("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_add("post_rst", 8'h05, 8'h05, 8'h0A, 1'b0, 1'b0);

      // Back-to-back with in_valid held
      pa[0] = 8'h49; pb[0] = 8'h16; ps[0] = 8'h64; pc[0] = 1'b0;
      pa[1] = 8'hAA; pb[1] = 8'h01; ps[1] = 8'h00; pc[1] = 1'b1;
      pa[2] = 8'h05; pb[2] = 8'h05; ps[2] = 8'h0A; pc[2] = 1'b0;
      idx      = 0;
      res      = 0;
      a        = pa[0];
      b        = pb[0];
      in_valid = 1'b1;
      for (int cyc = 1; cyc <= 40 && res < 3; cyc++) begin
         acc = in_ready && in_valid;
         @(posedge clk);
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < 3) begin
               a = pa[idx];
               b = pb[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            check_val("b2b_sum", 32'(sum), 32'(ps[res]));
            check_val("b2b_cout", 32'(carry_out), 32'(pc[res]));
            t_res[res] = cyc;
            res++;
         end
      end
      in_valid = 1'b0;
      check_val("b2b_count", 32'(res), 32'd3);
      if (res == 3) begin
         check_val("b2b_gap1", 32'(t_res[1] - t_res[0]), 32'd6);
         check_val("b2b_gap2", 32'(t_res[2] - t_res[1]), 32'd6);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
